// File: rtl/iter_mul_div.sv
// Iterative 32x32 multiply / 32/32 divide unit for the EX stage (mult, multu, div, divu).
// One radix-2 step per cycle; fixed 34-cycle stall, result held on out until the next operation.
module iter_mul_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] value_1,
    input  logic [31:0] value_2,
    input  logic [1:0]  operation,
    output logic [63:0] out,
    output logic        in_operation,
    output logic [1:0]  o_state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div_zero;
    logic [4:0]  r_cnt;
    logic [31:0] r_b;
    logic [32:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start;
    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic        w_neg;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;

    assign o_state_dbg = r_state;
    assign w_start     = (r_state == IDLE) & enable;
    assign w_is_div    = operation[1];
    assign w_signed    = operation[0];
    assign w_abs_a     = (w_signed && value_1[31]) ? (~value_1 + 32'd1) : value_1;
    assign w_abs_b     = (w_signed && value_2[31]) ? (~value_2 + 32'd1) : value_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // in_operation is combinational in IDLE so EX stalls in the request cycle itself.
    always_comb begin
        w_next       = r_state;
        in_operation = 1'b0;
        case (r_state)
            IDLE: begin
                in_operation = enable;
                if (enable) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                in_operation = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_next = FINISH;
                end
            end
            FINISH: begin
                in_operation = 1'b1;
                w_next       = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (reset) begin
            in_operation = 1'b0;
        end
    end

    // Multiply: {r_hi, r_lo} is the shift-add product register, multiplier in r_lo.
    assign w_mul_sum = r_lo[0] ? (r_hi + {1'b0, r_b}) : r_hi;

    // Divide: restoring step; r_hi is the remainder, r_lo shifts dividend out and quotient in.
    assign w_shift = {r_hi[31:0], r_lo[31]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_qbit  = ~w_diff[32];

    assign w_neg  = r_sign_a ^ r_sign_b;
    assign w_prod = {r_hi[31:0], r_lo};
    assign w_quot = w_neg ? (~r_lo + 32'd1) : r_lo;
    assign w_rem  = r_sign_a ? (~r_hi[31:0] + 32'd1) : r_hi[31:0];

    always_comb begin
        w_result = w_prod;
        if (!r_op[1]) begin
            w_result = w_neg ? (~w_prod + 64'd1) : w_prod;
        end else if (!r_div_zero) begin
            w_result = {w_rem, w_quot};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= 2'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= 5'd0;
            r_b        <= 32'd0;
            r_hi       <= 33'd0;
            r_lo       <= 32'd0;
            out        <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_op       <= operation;
                        r_cnt      <= 5'd0;
                        r_hi       <= 33'd0;
                        r_div_zero <= w_is_div && (value_2 == 32'd0);
                        if (w_is_div && (value_2 == 32'd0)) begin
                            // Zero divisor: raw dividend ends up as remainder, quotient all ones.
                            r_sign_a <= 1'b0;
                            r_sign_b <= 1'b0;
                            r_b      <= 32'd0;
                            r_lo     <= value_1;
                        end else begin
                            r_sign_a <= w_signed & value_1[31];
                            r_sign_b <= w_signed & value_2[31];
                            if (w_is_div) begin
                                r_b  <= w_abs_b;
                                r_lo <= w_abs_a;
                            end else begin
                                r_b  <= w_abs_a;
                                r_lo <= w_abs_b;
                            end
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_op[1]) begin
                        r_hi <= w_qbit ? w_diff : w_shift;
                        r_lo <= {r_lo[30:0], w_qbit};
                    end else begin
                        r_hi <= {1'b0, w_mul_sum[32:1]};
                        r_lo <= {w_mul_sum[0], r_lo[31:1]};
                    end
                end
                FINISH: begin
                    out <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul_div.sv
// Directed bench for iter_mul_div: hand-computed results, 34-cycle stall length,
// DONE lockout, output hold during BUSY and mid-operation reset.
module tb_iter_mul_div;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] value_1;
    logic [31:0] value_2;
    logic [1:0]  operation;
    logic [63:0] out;
    logic        in_operation;
    logic [1:0]  o_state_dbg;

    int n_cmp;
    int n_bad;

    iter_mul_div dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .value_1      (value_1),
        .value_2      (value_2),
        .operation    (operation),
        .out          (out),
        .in_operation (in_operation),
        .o_state_dbg  (o_state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Request at a negedge, count in_operation-high cycles, check the result in DONE.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit hold_en);
        int          cnt;
        logic [63:0] prev;
        @(negedge clk);
        enable    = 1'b1;
        operation = op;
        value_1   = a;
        value_2   = b;
        prev      = out;
        #1;
        check({tag, "_req_stall"}, {63'd0, in_operation}, 64'd1);
        cnt = 0;
        while (in_operation === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            if (cnt == 1) begin
                value_1   = $urandom;
                value_2   = $urandom;
                operation = 2'($urandom_range(0, 3));
                if (!hold_en) enable = 1'b0;
            end
            #1;
            if (cnt == 20) check({tag, "_out_hold"}, out, prev);
        end
        check({tag, "_stall_len"}, 64'(cnt), 64'd34);
        check({tag, "_result"}, out, exp);
        check({tag, "_done_state"}, {62'd0, o_state_dbg}, {62'd0, ST_DONE});
        if (hold_en) begin
            check({tag, "_done_no_stall"}, {63'd0, in_operation}, 64'd0);
            @(negedge clk);
            #1;
            check({tag, "_back_idle"}, {62'd0, o_state_dbg}, {62'd0, ST_IDLE});
            check({tag, "_result_kept"}, out, exp);
        end
        enable = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        operation = OP_MULTU;
        value_1   = 32'd9;
        value_2   = 32'd9;
        #3;
        check("rst_out", out, 64'd0);
        check("rst_stall", {63'd0, in_operation}, 64'd0);
        check("rst_state", {62'd0, o_state_dbg}, {62'd0, ST_IDLE});
        @(posedge clk);
        #1;
        check("rst_held_state", {62'd0, o_state_dbg}, {62'd0, ST_IDLE});
        reset  = 1'b0;
        enable = 1'b0;

        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        do_op("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        do_op("mult_2x3", OP_MULT, 32'd2, 32'd3, 64'h00000000_00000006, 1'b0);
        do_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        do_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0);
        do_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        do_op("div_neg_by0", OP_DIV, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF, 1'b0);
        do_op("mult_hold_en", OP_MULT, 32'd7, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 1'b1);

        // Reset in the middle of BUSY, then restart on the first edge after release.
        @(negedge clk);
        enable    = 1'b1;
        operation = OP_MULTU;
        value_1   = 32'h12345678;
        value_2   = 32'd9;
        repeat (11) @(negedge clk);
        enable = 1'b0;
        #1;
        check("mid_busy_state", {62'd0, o_state_dbg}, {62'd0, ST_BUSY});
        reset = 1'b1;
        #1;
        check("mid_rst_stall", {63'd0, in_operation}, 64'd0);
        check("mid_rst_out", out, 64'd0);
        check("mid_rst_state", {62'd0, o_state_dbg}, {62'd0, ST_IDLE});
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_op("multu_5x6", OP_MULTU, 32'd5, 32'd6, 64'h00000000_0000001E, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iter_mul_div.md
ITER_MUL_DIV -- requirements
Module: ITER_MUL_DIV

Interface
REQ-001 SHALL have one clock and one reset: the clock is named clk, and reset is asynchronous and active-high.
REQ-002 SHALL provide port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL provide port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL provide port enable, input, 1 bit: level request from the EX stage to start mult/multu/div/divu.
REQ-005 SHALL provide ports value_1 and value_2, inputs, 32 bits each: rs (multiplicand/dividend) and rt (multiplier/divisor).
REQ-006 SHALL provide port operation, input, 2 bits, encoded as {funct[1], !funct[0]}: 00 multu, 01 mult, 10 divu, 11 div.
REQ-007 SHALL provide port out, output, 64 bits, registered: {hi, lo}; product for multiply; {remainder, quotient} for divide.
REQ-008 SHALL provide port in_operation, output, 1 bit: busy/stall indication to EX.

Function
REQ-009 SHALL implement four states: IDLE, BUSY, FINISH and DONE.
REQ-010 SHALL drive in_operation = (state==BUSY) | (state==FINISH) | (state==IDLE & enable); the IDLE term is combinational so EX stalls in the request cycle itself.
REQ-011 SHALL, on a clock edge in IDLE with enable=1, latch the operation, absolute operand magnitudes (signed ops only), operand sign flags and the divisor-zero flag, clear the 5-bit iteration counter, and go to BUSY.
REQ-012 SHALL, in BUSY, perform one radix-2 iteration per cycle (shift-add multiply or restoring divide) for exactly 32 cycles, then go to FINISH.
REQ-013 SHALL, in FINISH, register out with sign correction applied, then go to DONE; in_operation stays high throughout FINISH.
REQ-014 SHALL, in DONE, hold in_operation=0, ignore enable, and go to IDLE on the next edge; this prevents a restart by the same still-present instruction.
REQ-015 SHALL give a fixed latency: in_operation high for exactly 34 consecutive cycles (1 request + 32 BUSY + 1 FINISH), and out valid from the first DONE cycle onward.
REQ-016 SHALL hold out stable from FINISH until the next FINISH; out SHALL NOT change during BUSY.
REQ-017 SHALL, for mult, negate the 64-bit product when sign(a) XOR sign(b) = 1; multu uses raw 32-bit operands with no correction.
REQ-018 SHALL, for div, negate the quotient when sign(a) XOR sign(b) = 1 and give the remainder the sign of the dividend; divu applies no correction.
REQ-019 SHALL, for a divisor of zero (div or divu), produce lo=0xFFFFFFFF and hi=value_1 as latched, with no sign correction and the full 34-cycle latency.
REQ-020 SHALL, for div 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0x00000000 without raising any error.
REQ-021 SHALL ignore the operand and operation inputs after the request edge; deasserting enable during BUSY/FINISH does not abort the operation.
REQ-022 SHALL use the counter at 5 bits, wrapping 31->0 on the transition to FINISH, and compute the remainder in a 33-bit datapath so restoring subtraction never overflows.

Reset
REQ-023 SHALL, while reset=1, force state=IDLE, out=0, counter=0 and all operand registers to 0, with in_operation=0.
REQ-024 SHALL, on reset mid-operation (BUSY/FINISH), immediately clear in_operation and out and discard the operation; no result is delivered.
REQ-025 SHALL accept enable=1 on the first edge after reset deasserts and start normally.

Verification
REQ-026 SHALL be covered by: multu 0xFFFFFFFF x 0xFFFFFFFF -> out=0xFFFFFFFE_00000001, with in_operation high for exactly 34 cycles and low in DONE.
REQ-027 SHALL be covered by: mult -3 (0xFFFFFFFD) x 7 -> out=0xFFFFFFFF_FFFFFFEB; then a back-to-back mult 2 x 3 requested the cycle after DONE -> out=0x00000000_00000006.
REQ-028 SHALL be covered by: div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 7 / 2 -> lo=3, hi=1.
REQ-029 SHALL be covered by: divu 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 SHALL be covered by: enable held high continuously through DONE -> exactly one operation executes, with no second busy period until IDLE.
REQ-031 SHALL be covered by: reset pulse at BUSY cycle 10 -> in_operation=0 and out=0 within the same cycle; a new multu 5 x 6 then gives 0x1E after 34 cycles.
